// File: rtl/note_sequencer_pkg.sv
// Shared types, pitch table and clamp helpers for the note sequencer.
package note_sequencer_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StLookup, StPlay} seq_state_t;

  localparam int unsigned RestBit     = 7;
  localparam logic [31:0] MinTempoDiv = 32'd4;
  localparam int unsigned TableWidth  = 18;

  // Top octave (MIDI 120..131) as fccw at 100 MHz with a 2^30 phase accumulator.
  localparam logic [TableWidth-1:0] PitchTable [12] = '{
    18'd89894,  18'd95239,  18'd100902, 18'd106902,
    18'd113259, 18'd119994, 18'd127129, 18'd134689,
    18'd142698, 18'd151185, 18'd160173, 18'd169697
  };

  function automatic logic [31:0] clamp_tempo(input logic [31:0] td);
    return (td < MinTempoDiv) ? MinTempoDiv : td;
  endfunction

  // Gate never reaches the next step's rise, leaving at least one low cycle.
  function automatic logic [31:0] clamp_gate(input logic [31:0] gl, input logic [31:0] td);
    return (gl > td - 32'd1) ? td - 32'd1 : gl;
  endfunction

endpackage

// File: rtl/note_sequencer_pitch_lut.sv
// MIDI note to oscillator fccw; one-cycle registered lookup.
module note_sequencer_pitch_lut
  import note_sequencer_pkg::*;
#(
  parameter int unsigned PhaseAccWidth = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [6:0]               note,
  output logic [PhaseAccWidth-1:0] fccw
);

  logic [3:0]               oct;
  logic [3:0]               semi;
  logic [6:0]               base;
  logic [PhaseAccWidth-1:0] fccw_d;
  logic [PhaseAccWidth-1:0] fccw_q;

  // Divide by 12 as a compare chain against octave boundaries.
  always_comb begin
    oct  = '0;
    base = '0;
    for (int k = 1; k <= 10; k++) begin
      if (note >= 7'(12 * k)) begin
        oct  = 4'(k);
        base = 7'(12 * k);
      end
    end
    semi = 4'(note - base);
  end

  assign fccw_d = PhaseAccWidth'(PitchTable[semi]) >> (4'd10 - oct);

  always_ff @(posedge clk) begin
    if (reset) begin
      fccw_q <= '0;
    end else if (en) begin
      fccw_q <= fccw_d;
    end
  end

  assign fccw = fccw_q;

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: plays a host-written 16-step note pattern at a programmable tempo.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned PhaseAccWidth = 30,
  parameter int unsigned Steps         = 16,
  localparam int unsigned AddrW        = $clog2(Steps)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [31:0]              tempo_div,
  input  logic [31:0]              gate_len,
  input  logic [4:0]               num_steps,
  input  logic                     wr_en,
  input  logic [AddrW-1:0]         wr_addr,
  input  logic [7:0]               wr_data,
  output logic [PhaseAccWidth-1:0] fccw,
  output logic                     start,
  output logic                     gate,
  output logic [AddrW-1:0]         step_idx,
  output logic                     busy
);

  localparam int unsigned NsW = AddrW + 1;

  seq_state_t       state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [AddrW-1:0] step_q, step_d, step_next;
  logic [31:0]      td_q, gl_q;
  logic [NsW-1:0]   ns_q, ns_clamped;
  logic [7:0]       mem_q [Steps];
  logic [7:0]       rd_data_q;
  logic             start_q, start_d;
  logic             gate_q, gate_d;
  logic [31:0]      gate_left_q, gate_left_d;

  always_comb begin
    if (num_steps == 5'd0) begin
      ns_clamped = NsW'(1);
    end else if (num_steps > 5'(Steps)) begin
      ns_clamped = NsW'(Steps);
    end else begin
      ns_clamped = NsW'(num_steps);
    end
  end

  assign step_next = ({1'b0, step_q} + NsW'(1) == ns_q) ? '0 : step_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    if (!run) begin
      state_d = StIdle;
      cnt_d   = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StFetch;
          cnt_d   = '0;
          step_d  = '0;
        end
        StFetch: begin
          state_d = StLookup;
          cnt_d   = 32'd1;
        end
        StLookup: begin
          state_d = StPlay;
          cnt_d   = 32'd2;
        end
        StPlay: begin
          if (cnt_q == td_q - 32'd1) begin
            state_d = StFetch;
            cnt_d   = '0;
            step_d  = step_next;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Gate rises together with the fccw update and then counts down its own length,
  // so it may run into the next step's fetch cycle.
  always_comb begin
    busy        = (state_q != StIdle);
    start_d     = 1'b0;
    gate_d      = gate_q;
    gate_left_d = gate_left_q;
    if (!run) begin
      gate_d      = 1'b0;
      gate_left_d = '0;
    end else if (state_q == StLookup && !rd_data_q[RestBit] && gl_q != '0) begin
      start_d     = 1'b1;
      gate_d      = 1'b1;
      gate_left_d = gl_q - 32'd1;
    end else if (gate_q) begin
      if (gate_left_q == '0) begin
        gate_d = 1'b0;
      end else begin
        gate_left_d = gate_left_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q     <= 1'b0;
      gate_q      <= 1'b0;
      gate_left_q <= '0;
      td_q        <= MinTempoDiv;
      gl_q        <= '0;
      ns_q        <= NsW'(1);
      rd_data_q   <= '0;
    end else begin
      start_q     <= start_d;
      gate_q      <= gate_d;
      gate_left_q <= gate_left_d;
      if (state_q == StFetch) begin
        td_q      <= clamp_tempo(tempo_div);
        gl_q      <= clamp_gate(gate_len, clamp_tempo(tempo_div));
        ns_q      <= ns_clamped;
        rd_data_q <= mem_q[step_q];
      end
    end
  end

  // Pattern RAM is deliberately not reset; a same-cycle write is seen on the next read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  note_sequencer_pitch_lut #(
    .PhaseAccWidth(PhaseAccWidth)
  ) u_pitch_lut (
    .clk  (clk),
    .reset(reset),
    .en   (state_q == StLookup),
    .note (rd_data_q[6:0]),
    .fccw (fccw)
  );

  assign start    = start_q;
  assign gate     = gate_q;
  assign step_idx = step_q;

endmodule
